// File: rtl/pic_prio_pkg.sv
// Shared constants for the priority interrupt controller: the CSR byte
// addresses, the interrupt ID width, the CLAIM valid-bit position, and a
// helper that builds the CLAIM read word.
package pic_prio_pkg;

  localparam int ID_W          = 6;
  localparam int CLAIM_VLD_BIT = 31;

  localparam logic [7:0] A_VERSION   = 8'h00;
  localparam logic [7:0] A_NAME      = 8'h04;
  localparam logic [7:0] A_EDGE      = 8'h10;
  localparam logic [7:0] A_POL       = 8'h14;
  localparam logic [7:0] A_ENABLE    = 8'h18;
  localparam logic [7:0] A_PENDING   = 8'h1C;
  localparam logic [7:0] A_CLEAR     = 8'h20;
  localparam logic [7:0] A_IRQ_IN    = 8'h24;
  localparam logic [7:0] A_THRESH    = 8'h28;
  localparam logic [7:0] A_CLAIM     = 8'h2C;
  localparam logic [7:0] A_COMPLETE  = 8'h30;
  localparam logic [7:0] A_INSERVICE = 8'h34;
  localparam logic [7:0] A_PRIO_BASE = 8'h40;

  // Successful claim word: valid flag at the top, source ID at the bottom.
  function automatic logic [31:0] claim_word(input logic [ID_W-1:0] id);
    logic [31:0] w;
    w                = '0;
    w[CLAIM_VLD_BIT] = 1'b1;
    w[ID_W-1:0]      = id;
    return w;
  endfunction

endpackage

// File: rtl/pic_prio_if.sv
// CSR bus between a host and the interrupt controller.
//   addr  : CSR byte address
//   rden  : read strobe; rdata is valid the cycle after
//   wren  : write strobe, wdata written on the same edge
//   rdata : registered read data
interface pic_prio_if;
  logic [7:0]  addr;
  logic        rden;
  logic        wren;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output addr, rden, wren, wdata, input rdata);
  modport slave  (input addr, rden, wren, wdata, output rdata);
endinterface

// File: rtl/pic_prio_arbiter.sv
// Picks the highest-priority eligible source (lowest index on ties) and
// registers the result.
//   clk, reset  : clock, synchronous active-high reset
//   elig_i      : eligible source vector
//   prio_i      : per-source priority
//   best_vld_o  : some source is eligible
//   best_id_o   : winning source (0 when none)
//   best_prio_o : winning priority (0 when none)
module pic_prio_arbiter
  import pic_prio_pkg::*;
#(
  parameter int NUM_IRQ   = 32,
  parameter int PRIO_BITS = 3
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_IRQ-1:0]                 elig_i,
  input  logic [NUM_IRQ-1:0][PRIO_BITS-1:0]  prio_i,
  output logic                               best_vld_o,
  output logic [ID_W-1:0]                    best_id_o,
  output logic [PRIO_BITS-1:0]               best_prio_o
);

  logic                 vld_d, vld_q;
  logic [ID_W-1:0]      id_d, id_q;
  logic [PRIO_BITS-1:0] prio_d, prio_q;

  // Ascending scan with strict '>' keeps the lowest index on ties.
  always_comb begin
    vld_d  = 1'b0;
    id_d   = '0;
    prio_d = '0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      if (elig_i[k] && (!vld_d || prio_i[k] > prio_d)) begin
        vld_d  = 1'b1;
        id_d   = ID_W'(k);
        prio_d = prio_i[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q  <= 1'b0;
      id_q   <= '0;
      prio_q <= '0;
    end else begin
      vld_q  <= vld_d;
      id_q   <= id_d;
      prio_q <= prio_d;
    end
  end

  assign best_vld_o  = vld_q;
  assign best_id_o   = id_q;
  assign best_prio_o = prio_q;

endmodule

// File: rtl/pic_prio_core.sv
// Priority interrupt controller core: per-source edge/level detection,
// pending/in-service tracking, threshold and nested-priority masking,
// claim/complete protocol over a small CSR bus.
//   clk, reset : clock, synchronous active-high reset
//   bus        : CSR slave port (addr/rden/wren/wdata/rdata)
//   irq_in     : clk-synchronous request lines
//   irq_out    : registered CPU interrupt request
//   irq_id     : registered ID of the current best candidate
module pic_prio_core
  import pic_prio_pkg::*;
#(
  parameter int          NUM_IRQ   = 32,
  parameter int          PRIO_BITS = 3,
  parameter logic [31:0] VERSION   = 32'h2024_0901,
  parameter logic [31:0] NAME      = "PICP"
) (
  input  logic               clk,
  input  logic               reset,
  pic_prio_if.slave          bus,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               irq_out,
  output logic [ID_W-1:0]    irq_id
);

  logic [NUM_IRQ-1:0]                edge_q, pol_q, en_q;
  logic [NUM_IRQ-1:0]                pend_q, pend_d;
  logic [NUM_IRQ-1:0]                insv_q, insv_d;
  logic [NUM_IRQ-1:0]                irq_dly_q;
  logic [NUM_IRQ-1:0][PRIO_BITS-1:0] prio_q;
  logic [PRIO_BITS-1:0]              thr_q;
  logic [31:0]                       rdata_q, rdata_d;

  logic [NUM_IRQ-1:0]   evt, elig, clr_mask, cmpl_mask, claim_mask, best_oh;
  logic [PRIO_BITS-1:0] run_prio;
  logic                 best_vld;
  logic [ID_W-1:0]      best_id;
  logic [PRIO_BITS-1:0] best_prio;
  logic                 claim_ok;
  logic [ID_W-1:0]      prio_idx;
  logic                 prio_hit;

  // Per-source event detect against the one-cycle delayed input copy.
  always_comb begin
    for (int k = 0; k < NUM_IRQ; k++) begin
      if (edge_q[k])
        evt[k] = en_q[k] & (pol_q[k] ? (irq_in[k] & ~irq_dly_q[k])
                                     : (~irq_in[k] & irq_dly_q[k]));
      else
        evt[k] = en_q[k] & (irq_in[k] == pol_q[k]);
    end
  end

  // Running priority: highest priority currently in service.
  always_comb begin
    run_prio = '0;
    for (int k = 0; k < NUM_IRQ; k++)
      if (insv_q[k] && prio_q[k] > run_prio) run_prio = prio_q[k];
  end

  // PRIO 0 drops out naturally since nothing is strictly above THRESHOLD 0.
  always_comb begin
    for (int k = 0; k < NUM_IRQ; k++)
      elig[k] = pend_q[k] & en_q[k] & (prio_q[k] > thr_q) & (prio_q[k] > run_prio);
  end

  pic_prio_arbiter #(.NUM_IRQ(NUM_IRQ), .PRIO_BITS(PRIO_BITS)) u_arb (
    .clk         (clk),
    .reset       (reset),
    .elig_i      (elig),
    .prio_i      (prio_q),
    .best_vld_o  (best_vld),
    .best_id_o   (best_id),
    .best_prio_o (best_prio)
  );

  assign irq_out = best_vld;
  assign irq_id  = best_id;

  // One-hot of the registered winner; the claim re-checks PENDING because
  // the winner may have been cleared since it was registered.
  always_comb begin
    for (int k = 0; k < NUM_IRQ; k++)
      best_oh[k] = (best_id == ID_W'(k));
  end

  assign claim_ok = bus.rden && (bus.addr == A_CLAIM) && best_vld && |(pend_q & best_oh);

  always_comb begin
    claim_mask = claim_ok ? best_oh : '0;
    clr_mask   = (bus.wren && bus.addr == A_CLEAR) ? bus.wdata[NUM_IRQ-1:0] : '0;
    for (int k = 0; k < NUM_IRQ; k++)
      cmpl_mask[k] = bus.wren && (bus.addr == A_COMPLETE) && (bus.wdata[ID_W-1:0] == ID_W'(k));
    // New events win over a same-cycle clear or claim.
    pend_d = (pend_q & ~clr_mask & ~claim_mask) | evt;
    insv_d = (insv_q & ~cmpl_mask) | claim_mask;
  end

  // PRIO[k] lives at 0x40 + 4*k.
  assign prio_idx = bus.addr[7:2] - A_PRIO_BASE[7:2];
  assign prio_hit = (bus.addr >= A_PRIO_BASE) && (bus.addr[1:0] == 2'b00);

  always_comb begin
    rdata_d = '0;
    case (bus.addr)
      A_VERSION:   rdata_d = VERSION;
      A_NAME:      rdata_d = NAME;
      A_EDGE:      rdata_d[NUM_IRQ-1:0] = edge_q;
      A_POL:       rdata_d[NUM_IRQ-1:0] = pol_q;
      A_ENABLE:    rdata_d[NUM_IRQ-1:0] = en_q;
      A_PENDING:   rdata_d[NUM_IRQ-1:0] = pend_q;
      A_IRQ_IN:    rdata_d[NUM_IRQ-1:0] = irq_in;
      A_THRESH:    rdata_d[PRIO_BITS-1:0] = thr_q;
      A_CLAIM:     if (claim_ok) rdata_d = claim_word(best_id);
      A_INSERVICE: rdata_d[NUM_IRQ-1:0] = insv_q;
      default: begin
        for (int k = 0; k < NUM_IRQ; k++)
          if (prio_hit && prio_idx == ID_W'(k)) rdata_d[PRIO_BITS-1:0] = prio_q[k];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      edge_q    <= '0;
      pol_q     <= '0;
      en_q      <= '0;
      pend_q    <= '0;
      insv_q    <= '0;
      irq_dly_q <= '0;
      prio_q    <= '0;
      thr_q     <= '0;
      rdata_q   <= '0;
    end else begin
      irq_dly_q <= irq_in;
      pend_q    <= pend_d;
      insv_q    <= insv_d;
      if (bus.rden) rdata_q <= rdata_d;
      if (bus.wren) begin
        case (bus.addr)
          A_EDGE:   edge_q <= bus.wdata[NUM_IRQ-1:0];
          A_POL:    pol_q  <= bus.wdata[NUM_IRQ-1:0];
          A_ENABLE: en_q   <= bus.wdata[NUM_IRQ-1:0];
          A_THRESH: thr_q  <= bus.wdata[PRIO_BITS-1:0];
          default: begin
            for (int k = 0; k < NUM_IRQ; k++)
              if (prio_hit && prio_idx == ID_W'(k)) prio_q[k] <= bus.wdata[PRIO_BITS-1:0];
          end
        endcase
      end
    end
  end

  assign bus.rdata = rdata_q;

endmodule
